ysyx_24090010_trap_seq: RTL and testbench
=========================================

Name: ysyx_24090010_trap_seq

Overview:
Trap sequencer: the write-side initiator that drives the register file's CSR write port (mepc/mcause/mstatus/mtvec) and reads back its CSR outputs.
- Accepts one trap-class instruction per handshake from EXU (ecall, mret, ebreak, illegal).
- Issues the required CSR writes one per cycle, then hands a redirect PC to IFU.
- Owns all architectural trap side effects. Regular csrrw/csrrs writes are not routed through this block.

Parameters:
- CAUSE_ECALL, 11, mcause value written on ecall (M-mode).
- CAUSE_ILLEGAL, 2, mcause value written on illegal instruction.
- MPP_FIXED, 2'b11, value forced into mstatus.MPP on trap entry and on mret.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EXU presents an op
- in_ready  out  1  sequencer can accept
- in_op  in  3  0 NONE, 1 ECALL, 2 MRET, 3 EBREAK, 4 ILLEGAL, 5-7 treated as NONE
- in_pc  in  32  PC of the presented instruction
- mtvec  in  32  current mtvec from register file
- mepc  in  32  current mepc from register file
- mstatus  in  32  current mstatus from register file
- csr_wen  out  1  CSR write strobe to register file
- csr_sel  out  2  00 mepc, 01 mcause, 10 mstatus, 11 mtvec (never driven 11)
- csr_wdata  out  32  full-word CSR write data
- redir_valid  out  1  redirect PC valid to IFU
- redir_pc  out  32  redirect target
- redir_ready  in  1  IFU accepts redirect
- halt  out  1  sticky halt after ebreak
- trap_cnt  out  32  number of completed trap entries (ecall + illegal)

Behaviour:
- Reset (synchronous): state IDLE; csr_wen=0, csr_sel=0, csr_wdata=0, redir_valid=0, redir_pc=0, halt=0, trap_cnt=0; snapshots cleared. Reset wins over every other event, including mid-sequence: partially issued CSR writes are not undone and no redirect is produced.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIR, HALT.
- in_ready = (state==IDLE). Accept = in_valid & in_ready.
- On accept, in the same edge, latch:
  - in_pc into pc_s;
  - mtvec into tvec_s;
  - mepc into epc_s;
  - mstatus into st_s;
  - cause into cause_s.
  - Later CSR writes never alter these snapshots.
- IDLE transitions on accept:
  - ECALL or ILLEGAL -> W_MEPC.
  - MRET -> W_MSTATUS with mret flag set.
  - EBREAK -> HALT.
  - NONE -> stay IDLE (consumed, no side effects).
- W_MEPC: csr_wen=1, sel=00, wdata=pc_s -> W_MCAUSE.
- W_MCAUSE: csr_wen=1, sel=01, wdata=cause_s -> W_MSTATUS.
- W_MSTATUS: csr_wen=1, sel=10 -> REDIR. Write data is st_s with:
  - trap entry: MPIE(bit7)=st_s[3], MIE(bit3)=0, MPP(12:11)=MPP_FIXED.
  - mret: MIE=st_s[7], MPIE=1, MPP=MPP_FIXED.
  - All other bits are passed from st_s unchanged.
- REDIR:
  - redir_valid=1.
  - redir_pc = {tvec_s[31:2],2'b00} for trap entry (direct mode only); {epc_s[31:2],2'b00} for mret.
  - Held stable until redir_ready; on redir_valid & redir_ready -> IDLE.
  - trap_cnt increments by 1 (wraps at 2^32) on that same handshake, trap entry only.
- HALT: halt=1, in_ready=0, no CSR writes, no redirect; exits only via rst.
- csr_wen is registered with state: exactly one write per W_* cycle, never in IDLE/REDIR/HALT.
- Latency (accept edge = T):
  - ecall/illegal: writes at T+1, T+2, T+3; redir_valid from T+4.
  - mret: mstatus write at T+1; redir_valid from T+2.
  - Next accept is possible the cycle after the redirect handshake.
- redir_ready asserted outside REDIR is ignored. in_valid outside IDLE is ignored (EXU holds its request).

Test Plan:
- ecall: rst, mtvec=0x80000100, mstatus=0x1808, in_pc=0x80000040, ECALL, redir_ready=1 -> mepc<=0x80000040, mcause<=11, mstatus<=0x1880 on consecutive cycles; redir_pc=0x80000100 at T+4; trap_cnt=1.
- mret: mepc=0x80000044, mstatus=0x1880, MRET -> mstatus write 0x1888 at T+1; redir_pc=0x80000044 at T+2; trap_cnt unchanged.
- Redirect backpressure: ecall with redir_ready=0 for 5 cycles -> redir_valid and redir_pc held constant, in_ready=0, no extra csr_wen; IDLE one cycle after redir_ready=1.
- Snapshot: regfile updates mtvec to 0x0 during W_MCAUSE -> redir_pc still uses the latched 0x80000100. ILLEGAL -> mcause write = 2.
- ebreak then ecall -> halt=1 sticky, in_ready=0, no csr_wen; rst -> halt=0, in_ready=1.
- Reset mid-sequence: rst asserted in W_MCAUSE -> next cycle IDLE, csr_wen=0, redir_valid=0, trap_cnt=0. NONE op accepted -> no outputs toggle.

Source files
------------

// File: rtl/ysyx_24090010_trap_seq.sv
// Trap sequencer. Takes one trap-class op from EXU, replays the architectural
// CSR side effects (mepc, mcause, mstatus) one write per cycle, then offers a
// redirect PC to IFU. ebreak parks the block in a sticky halt until reset.
module ysyx_24090010_trap_seq #(
    parameter logic [31:0] CAUSE_ECALL   = 32'd11,
    parameter logic [31:0] CAUSE_ILLEGAL = 32'd2,
    parameter logic [1:0]  MPP_FIXED     = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_pc,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] mstatus,
    output logic        csr_wen,
    output logic [1:0]  csr_sel,
    output logic [31:0] csr_wdata,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    input  logic        redir_ready,
    output logic        halt,
    output logic [31:0] trap_cnt
);

    localparam logic [2:0] OP_ECALL   = 3'd1;
    localparam logic [2:0] OP_MRET    = 3'd2;
    localparam logic [2:0] OP_EBREAK  = 3'd3;
    localparam logic [2:0] OP_ILLEGAL = 3'd4;

    localparam logic [1:0] SEL_MEPC    = 2'b00;
    localparam logic [1:0] SEL_MCAUSE  = 2'b01;
    localparam logic [1:0] SEL_MSTATUS = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MSTATUS,
        REDIR,
        HALT
    } state_t;

    state_t      state_q;
    logic        mret_q;
    logic [31:0] pc_s_q, tvec_s_q, epc_s_q, st_s_q, cause_s_q;
    logic        csr_wen_q, redir_valid_q, halt_q;
    logic [1:0]  csr_sel_q;
    logic [31:0] csr_wdata_q, redir_pc_q, trap_cnt_q;

    logic        accept;
    logic [31:0] cause_d;

    // mstatus image for trap entry: stash MIE into MPIE, disable MIE, force MPP
    function automatic logic [31:0] st_entry(input logic [31:0] st);
        logic [31:0] r;
        r        = st;
        r[7]     = st[3];
        r[3]     = 1'b0;
        r[12:11] = MPP_FIXED;
        return r;
    endfunction

    // mstatus image for mret: restore MIE from MPIE, set MPIE, force MPP
    function automatic logic [31:0] st_mret(input logic [31:0] st);
        logic [31:0] r;
        r        = st;
        r[3]     = st[7];
        r[7]     = 1'b1;
        r[12:11] = MPP_FIXED;
        return r;
    endfunction

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    // Cause code captured alongside the other snapshots at accept time
    always_comb begin
        cause_d = 32'd0;
        if (in_op == OP_ECALL)   cause_d = CAUSE_ECALL;
        if (in_op == OP_ILLEGAL) cause_d = CAUSE_ILLEGAL;
    end

    // Sequencer FSM; every output is loaded with the value for the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mret_q        <= 1'b0;
            pc_s_q        <= '0;
            tvec_s_q      <= '0;
            epc_s_q       <= '0;
            st_s_q        <= '0;
            cause_s_q     <= '0;
            csr_wen_q     <= 1'b0;
            csr_sel_q     <= '0;
            csr_wdata_q   <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            halt_q        <= 1'b0;
            trap_cnt_q    <= '0;
        end else begin
            csr_wen_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        pc_s_q    <= in_pc;
                        tvec_s_q  <= mtvec;
                        epc_s_q   <= mepc;
                        st_s_q    <= mstatus;
                        cause_s_q <= cause_d;
                        case (in_op)
                            OP_ECALL, OP_ILLEGAL: begin
                                state_q     <= W_MEPC;
                                mret_q      <= 1'b0;
                                csr_wen_q   <= 1'b1;
                                csr_sel_q   <= SEL_MEPC;
                                csr_wdata_q <= in_pc;
                            end
                            OP_MRET: begin
                                state_q     <= W_MSTATUS;
                                mret_q      <= 1'b1;
                                csr_wen_q   <= 1'b1;
                                csr_sel_q   <= SEL_MSTATUS;
                                csr_wdata_q <= st_mret(mstatus);
                            end
                            OP_EBREAK: begin
                                state_q <= HALT;
                                halt_q  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                W_MEPC: begin
                    state_q     <= W_MCAUSE;
                    csr_wen_q   <= 1'b1;
                    csr_sel_q   <= SEL_MCAUSE;
                    csr_wdata_q <= cause_s_q;
                end
                W_MCAUSE: begin
                    state_q     <= W_MSTATUS;
                    csr_wen_q   <= 1'b1;
                    csr_sel_q   <= SEL_MSTATUS;
                    csr_wdata_q <= st_entry(st_s_q);
                end
                W_MSTATUS: begin
                    state_q       <= REDIR;
                    redir_valid_q <= 1'b1;
                    redir_pc_q    <= mret_q ? {epc_s_q[31:2], 2'b00}
                                            : {tvec_s_q[31:2], 2'b00};
                end
                REDIR: begin
                    if (redir_ready) begin
                        state_q       <= IDLE;
                        redir_valid_q <= 1'b0;
                        if (!mret_q) trap_cnt_q <= trap_cnt_q + 32'd1;
                    end
                end
                HALT: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign csr_wen     = csr_wen_q;
    assign csr_sel     = csr_sel_q;
    assign csr_wdata   = csr_wdata_q;
    assign redir_valid = redir_valid_q;
    assign redir_pc    = redir_pc_q;
    assign halt        = halt_q;
    assign trap_cnt    = trap_cnt_q;

endmodule

// File: tb/tb_ysyx_24090010_trap_seq.sv
// Bench for the trap sequencer: a transaction-level model (queue of pending CSR
// writes plus one pending redirect) is checked against the DUT every cycle,
// with directed literal checks on the key scenarios and a random phase.
module tb_ysyx_24090010_trap_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_pc, mtvec, mepc, mstatus;
    logic        csr_wen;
    logic [1:0]  csr_sel;
    logic [31:0] csr_wdata;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        redir_ready;
    logic        halt;
    logic [31:0] trap_cnt;

    int checks = 0;
    int fails  = 0;

    ysyx_24090010_trap_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_pc(in_pc), .mtvec(mtvec), .mepc(mepc),
        .mstatus(mstatus), .csr_wen(csr_wen), .csr_sel(csr_sel),
        .csr_wdata(csr_wdata), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .redir_ready(redir_ready), .halt(halt), .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [33:0] wq[$];       // {sel, data} of CSR writes still to appear
    bit          m_rp;        // redirect owed after the writes drain
    logic [31:0] m_rpc;
    bit          m_rtrap;
    bit          m_halt;
    logic [31:0] m_cnt;
    bit          m_started = 0;
    bit          m_acc;

    function automatic bit m_ready();
        return !m_halt && wq.size() == 0 && !m_rp;
    endfunction

    function automatic logic [31:0] entry_img(input logic [31:0] st);
        return (st & ~32'h0000_1888) | (st[3] ? 32'h80 : 32'h0) | 32'h1800;
    endfunction

    function automatic logic [31:0] mret_img(input logic [31:0] st);
        return (st & ~32'h0000_1888) | (st[7] ? 32'h8 : 32'h0) | 32'h1880;
    endfunction

    always @(posedge clk) begin
        m_acc = in_valid && m_ready();
        if (rst) begin
            wq.delete();
            m_rp   = 0;
            m_halt = 0;
            m_cnt  = 0;
        end else begin
            if (wq.size() > 0) void'(wq.pop_front());
            else if (m_rp && redir_ready) begin
                m_rp = 0;
                if (m_rtrap) m_cnt = m_cnt + 1;
            end
            if (m_acc) begin
                if (in_op == 3'd1 || in_op == 3'd4) begin
                    wq.push_back({2'b00, in_pc});
                    wq.push_back({2'b01, (in_op == 3'd1) ? 32'd11 : 32'd2});
                    wq.push_back({2'b10, entry_img(mstatus)});
                    m_rp = 1; m_rtrap = 1; m_rpc = mtvec & ~32'h3;
                end else if (in_op == 3'd2) begin
                    wq.push_back({2'b10, mret_img(mstatus)});
                    m_rp = 1; m_rtrap = 0; m_rpc = mepc & ~32'h3;
                end else if (in_op == 3'd3) begin
                    m_halt = 1;
                end
            end
        end
        m_started = 1;
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_started) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
            chk("halt", {31'd0, halt}, {31'd0, m_halt});
            chk("trap_cnt", trap_cnt, m_cnt);
            chk("csr_wen", {31'd0, csr_wen}, {31'd0, (wq.size() > 0)});
            if (wq.size() > 0) begin
                chk("csr_sel", {30'd0, csr_sel}, {30'd0, wq[0][33:32]});
                chk("csr_wdata", csr_wdata, wq[0][31:0]);
            end
            chk("redir_valid", {31'd0, redir_valid}, {31'd0, (wq.size() == 0 && m_rp)});
            if (wq.size() == 0 && m_rp) chk("redir_pc", redir_pc, m_rpc);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_op = 0; in_pc = 0; mtvec = 0; mepc = 0;
        mstatus = 0; redir_ready = 0;
        tick(); tick();
        rst = 0;
        chk("rst_sel", {30'd0, csr_sel}, 32'd0);
        chk("rst_wdata", csr_wdata, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // ecall
        mtvec = 32'h8000_0100; mstatus = 32'h1808; in_pc = 32'h8000_0040;
        in_op = 3'd1; in_valid = 1; redir_ready = 1;
        tick(); in_valid = 0;
        chk("ecall_mepc", csr_wdata, 32'h8000_0040);
        tick();
        chk("ecall_mcause", csr_wdata, 32'd11);
        mtvec = 32'h0;                         // regfile change must not leak in
        tick();
        chk("ecall_mstatus", csr_wdata, 32'h1880);
        tick();
        chk("ecall_redir", redir_pc, 32'h8000_0100);
        tick();
        chk("ecall_cnt", trap_cnt, 32'd1);

        // mret
        mepc = 32'h8000_0044; mstatus = 32'h1880; in_op = 3'd2; in_valid = 1;
        tick(); in_valid = 0;
        chk("mret_mstatus", csr_wdata, 32'h1888);
        tick();
        chk("mret_redir", redir_pc, 32'h8000_0044);
        tick();
        chk("mret_cnt", trap_cnt, 32'd1);

        // redirect backpressure
        mtvec = 32'h8000_0100; redir_ready = 0; in_op = 3'd1; in_valid = 1;
        tick(); in_valid = 0;
        tick(); tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, redir_valid}, 32'd1);
            chk("bp_pc", redir_pc, 32'h8000_0100);
            tick();
        end
        redir_ready = 1;
        tick();
        chk("bp_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_cnt", trap_cnt, 32'd2);

        // illegal
        in_op = 3'd4; in_valid = 1;
        tick(); in_valid = 0;
        tick();
        chk("ill_cause", csr_wdata, 32'd2);
        tick(); tick(); tick();
        chk("ill_cnt", trap_cnt, 32'd3);

        // ebreak then ecall
        in_op = 3'd3; in_valid = 1;
        tick();
        in_op = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_sticky", {31'd0, halt}, 32'd1);
            chk("halt_nowen", {31'd0, csr_wen}, 32'd0);
        end
        in_valid = 0; rst = 1;
        tick(); rst = 0;
        chk("halt_clear", {31'd0, halt}, 32'd0);
        chk("halt_ready", {31'd0, in_ready}, 32'd1);

        // reset mid-sequence
        in_op = 3'd1; in_valid = 1;
        tick(); in_valid = 0;
        tick(); rst = 1;
        tick(); rst = 0;
        chk("midrst_wen", {31'd0, csr_wen}, 32'd0);
        chk("midrst_rv", {31'd0, redir_valid}, 32'd0);
        chk("midrst_cnt", trap_cnt, 32'd0);

        // NONE op
        in_op = 3'd0; in_valid = 1;
        tick(); in_valid = 0;
        chk("none_wen", {31'd0, csr_wen}, 32'd0);
        chk("none_ready", {31'd0, in_ready}, 32'd1);

        // random phase
        for (int c = 0; c < 4000; c++) begin
            rst         = ($urandom_range(0, 59) == 0);
            in_valid    = $urandom_range(0, 1) == 1;
            in_op       = 3'($urandom_range(0, 7));
            in_pc       = $urandom;
            mtvec       = $urandom;
            mepc        = $urandom;
            mstatus     = $urandom;
            redir_ready = $urandom_range(0, 1) == 1;
            tick();
        end

        rst = 0; in_valid = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
